// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling constants and default
// frame parameters, used by both the receiver and the transmitter.
package uart_pkg;

  localparam int OSR         = 16;  // ticks per bit
  localparam int MID         = 7;   // tick index at the middle of the start bit
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bus: serial line and sampling strobe in, received word and flags out.
interface uart_rx_if import uart_pkg::*; #(
  parameter int DBIT = DBIT_DEF
);

  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;

  modport master (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err, parity_err
  );

  modport slave (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err, parity_err
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to 1, the idle line level.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q a true two-stage shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver. Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx import uart_pkg::*; #(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int PAR_ODD = 0
) (
  input logic       clk,
  input logic       reset,
  uart_rx_if.master bus
);

  localparam int S_W = (SB_TICK > OSR) ? 5 : 4;
  localparam int N_W = $clog2(DBIT);

  localparam logic [S_W-1:0] S_MID      = S_W'(MID);
  localparam logic [S_W-1:0] S_BIT_END  = S_W'(OSR - 1);
  localparam logic [S_W-1:0] S_STOP_END = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST     = N_W'(DBIT - 1);

  if (DBIT < 5 || DBIT > 9 || SB_TICK < OSR || SB_TICK > 2 * OSR ||
      PAR_ODD < 0 || PAR_ODD > 1) begin : g_bad_param
    $error("uart_rx: unsupported DBIT/SB_TICK/PAR_ODD");
  end

  logic [2:0]      state;
  logic [S_W-1:0]  s;
  logic [N_W-1:0]  n;
  logic [DBIT-1:0] b;
  logic            rx_s;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_BIT = 1'(PAR_ODD);
  logic p_bad;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      s                <= '0;
      n                <= '0;
      b                <= '0;
`ifdef UART_RX_PARITY_EN
      p_bad            <= 1'b0;
`endif
      bus.dout         <= '0;
      bus.rx_done_tick <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.parity_err   <= 1'b0;
    end else begin
      // NOTE: default-low every cycle so the done strobe is a single-cycle pulse.
      bus.rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s == S_MID) begin
              // A line that is high again mid start bit was a glitch.
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s == S_BIT_END) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bus.s_tick) begin
            if (s == S_BIT_END) begin
              p_bad <= (^b) ^ rx_s ^ PAR_BIT;
              s     <= '0;
              state <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (bus.s_tick) begin
            if (s == S_STOP_END) begin
              bus.dout         <= b;
              bus.frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              bus.parity_err   <= p_bad;
`else
              bus.parity_err   <= 1'b0;
`endif
              bus.rx_done_tick <= 1'b1;
              state            <= IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames against a frame-level model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DBIT    = DBIT_DEF;
  localparam int SB_TICK = SB_TICK_DEF;
  localparam int PAR_ODD = 0;
  localparam int TICK_DIV = 16;

`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR   = 1'b1;
  localparam int PAR_TICKS = OSR;
`else
  localparam bit HAS_PAR   = 1'b0;
  localparam int PAR_TICKS = 0;
`endif

  // Start bit + data bits + optional parity + stop, in ticks.
  localparam int FRAME_TICKS = OSR + OSR * DBIT + PAR_TICKS + SB_TICK;

  typedef struct {
    logic [DBIT-1:0] data;
    logic            fe;
    logic            pe;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  uart_rx_if #(.DBIT(DBIT)) bus ();

  uart_rx #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK),
    .PAR_ODD (PAR_ODD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              tick_cnt = 0;
  int              frames_sent = 0;
  exp_t            exp_q[$];
  int              done_ticks[$];
  logic [DBIT-1:0] last_exp = '0;
  logic            prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Baud tick generator: one-cycle strobe every TICK_DIV clocks, driven on the falling edge.
  initial begin
    bus.s_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      bus.s_tick = 1'b1;
      @(negedge clk);
      bus.s_tick = 1'b0;
    end
  end

  always @(posedge clk) if (bus.s_tick) tick_cnt++;

  // Every done pulse is matched against the oldest outstanding expected frame.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.rx_done_tick) begin
      check("done_width", prev_done, 1'b0);
      done_ticks.push_back(tick_cnt);
      check("done_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dout", bus.dout, e.data);
        check("frame_err", bus.frame_err, e.fe);
        check("parity_err", bus.parity_err, e.pe);
      end
    end
    prev_done = bus.rx_done_tick;
  end

  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      while (!bus.s_tick) @(posedge clk);
    end
  endtask

  task automatic set_rx(input logic v);
    @(negedge clk);
    bus.rx = v;
  endtask

  // Drives one whole frame and records what the receiver must report for it.
  task automatic send_frame(input logic [DBIT-1:0] data, input bit stop_ok, input bit par_ok);
    exp_t e;
    logic par;
    e.data = data;
    e.fe   = !stop_ok;
    e.pe   = HAS_PAR ? !par_ok : 1'b0;
    exp_q.push_back(e);
    last_exp = data;
    frames_sent++;
    set_rx(1'b0);
    wait_ticks(OSR);
    for (int i = 0; i < DBIT; i++) begin
      set_rx(data[i]);
      wait_ticks(OSR);
    end
    if (HAS_PAR) begin
      par = (^data) ^ 1'(PAR_ODD) ^ !par_ok;
      set_rx(par);
      wait_ticks(OSR);
    end
    // Stop level is held across the sample point, then the line returns to idle.
    set_rx(stop_ok);
    wait_ticks(SB_TICK - 4);
    set_rx(1'b1);
    wait_ticks(4);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 2 * FRAME_TICKS * TICK_DIV;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int n0;
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout", bus.dout, '0);
    check("rst_done", bus.rx_done_tick, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_parity_err", bus.parity_err, 1'b0);
    reset = 1'b0;
    wait_ticks(3);

    send_frame(DBIT'(8'h55), 1'b1, 1'b1);
    drain("drain_55");

    send_frame(DBIT'(8'hA5), 1'b0, 1'b1);
    send_frame(DBIT'(8'h3C), 1'b1, 1'b1);
    drain("drain_a5_3c");

    // Short low pulse: rejected as a glitch, output untouched.
    n0 = done_ticks.size();
    set_rx(1'b0);
    wait_ticks(4);
    set_rx(1'b1);
    wait_ticks(20);
    check("glitch_no_done", done_ticks.size(), n0);
    check("glitch_dout", bus.dout, last_exp);

    // Reset in the middle of data bit 3 of 0xFF.
    n0 = done_ticks.size();
    set_rx(1'b0);
    wait_ticks(OSR);
    set_rx(1'b1);
    wait_ticks(3 * OSR + 8);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_dout", bus.dout, '0);
    check("midrst_frame_err", bus.frame_err, 1'b0);
    check("midrst_done", bus.rx_done_tick, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    last_exp = '0;
    wait_ticks(FRAME_TICKS);
    check("midrst_no_done", done_ticks.size(), n0);
    send_frame(DBIT'(8'h81), 1'b1, 1'b1);
    drain("drain_81");

    // Back-to-back frames: done pulses one frame length apart.
    n0 = done_ticks.size();
    send_frame(DBIT'(8'h00), 1'b1, 1'b1);
    send_frame(DBIT'(8'hFF), 1'b1, 1'b1);
    drain("drain_b2b");
    check("b2b_count", done_ticks.size() - n0, 2);
    if (done_ticks.size() >= n0 + 2)
      check("b2b_spacing", done_ticks[n0+1] - done_ticks[n0], FRAME_TICKS);

`ifdef UART_RX_PARITY_EN
    send_frame(DBIT'(8'h07), 1'b1, 1'b1);
    send_frame(DBIT'(8'h07), 1'b1, 1'b0);
    drain("drain_parity");
`endif

    for (int i = 0; i < 10; i++) begin
      wait_ticks($urandom_range(0, 6));
      send_frame(DBIT'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    drain("drain_random");
    wait_ticks(4);
    check("done_total", done_ticks.size(), frames_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
